// File: rtl/ft_pkg.sv
// Shared types and helpers for the lockstep recovery sequencer.
package ft_pkg;

   localparam int CNT_WIDTH       = 8;
   localparam int BEAT_ADDR_WIDTH = 5;
   localparam int BEAT_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      FT_IDLE     = 3'd0,
      FT_HALTING  = 3'd1,
      FT_RESTORE  = 3'd2,
      FT_SET_PC   = 3'd3,
      FT_RELEASE  = 3'd4
   } ft_rst_state_e;

   typedef struct packed {
      logic [BEAT_ADDR_WIDTH-1:0] addr;
      logic [BEAT_DATA_WIDTH-1:0] data;
   } ft_beat_t;

   // Recovery counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] cnt);
      if (cnt == {CNT_WIDTH{1'b1}}) begin
         return cnt;
      end else begin
         return cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/ft_restore_ctrl_if.sv
// Bundle between comparator/cores (master side) and the recovery sequencer (slave side).
interface ft_restore_ctrl_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  halt_i;
   logic                  shift_i;
   logic [ADDR_WIDTH-1:0] addr_i;
   logic [DATA_WIDTH-1:0] data_i;
   logic                  resume_i;
   logic                  reset_i;
   logic [DATA_WIDTH-1:0] spc_i;
   logic                  halted_i;
   logic                  dbg_gnt_i;
   logic                  core_halt_o;
   logic                  core_rst_o;
   logic                  dbg_req_o;
   logic                  dbg_pc_sel_o;
   logic [ADDR_WIDTH-1:0] dbg_addr_o;
   logic [DATA_WIDTH-1:0] dbg_wdata_o;
   logic                  busy_o;
   logic                  done_o;
   logic                  overflow_o;
   logic [7:0]            recovery_cnt_o;

   modport master (
      output halt_i, shift_i, addr_i, data_i, resume_i, reset_i, spc_i, halted_i, dbg_gnt_i,
      input  core_halt_o, core_rst_o, dbg_req_o, dbg_pc_sel_o, dbg_addr_o, dbg_wdata_o,
             busy_o, done_o, overflow_o, recovery_cnt_o
   );

   modport slave (
      input  halt_i, shift_i, addr_i, data_i, resume_i, reset_i, spc_i, halted_i, dbg_gnt_i,
      output core_halt_o, core_rst_o, dbg_req_o, dbg_pc_sel_o, dbg_addr_o, dbg_wdata_o,
             busy_o, done_o, overflow_o, recovery_cnt_o
   );
endinterface

// File: rtl/ft_sync_fifo.sv
// Synchronous FIFO with combinational head read; pointers carry one extra wrap bit.
module ft_sync_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int PTR_WIDTH = $clog2(DEPTH);
   localparam logic [PTR_WIDTH:0] PTR_ONE  = {{PTR_WIDTH{1'b0}}, 1'b1};
   localparam logic [PTR_WIDTH:0] PTR_ZERO = {(PTR_WIDTH+1){1'b0}};

   logic [PTR_WIDTH:0] wr_ptr_r;
   logic [PTR_WIDTH:0] rd_ptr_r;
   logic [WIDTH-1:0]   mem_r [DEPTH];
   logic               full_s;
   logic               empty_s;
   logic               do_push_s;
   logic               do_pop_s;

   assign empty_s   = (wr_ptr_r == rd_ptr_r);
   assign full_s    = (wr_ptr_r[PTR_WIDTH] != rd_ptr_r[PTR_WIDTH]) &&
                      (wr_ptr_r[PTR_WIDTH-1:0] == rd_ptr_r[PTR_WIDTH-1:0]);
   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   assign do_push_s = push & (~full_s | pop);
   assign do_pop_s  = pop & ~empty_s;

   assign rdata = mem_r[rd_ptr_r[PTR_WIDTH-1:0]];
   assign full  = full_s;
   assign empty = empty_s;

   // Pointer update; clear wins over any push/pop in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
      end else if (clr) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
   end

   // Beat storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r[PTR_WIDTH-1:0]] <= wdata;
   end
endmodule

// File: rtl/ft_restore_ctrl.sv
// Recovery sequencer: halts the lockstep cores, replays buffered restore beats
// through the debug port, writes the safe PC and optionally pulses core reset.
module ft_restore_ctrl
   import ft_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 32,
   parameter int RST_CYCLES = 4
) (
   input logic          clk_i,
   input logic          rst_i,
   ft_restore_ctrl_if.slave bus
);
   localparam logic [2:0] S_IDLE    = FT_IDLE;
   localparam logic [2:0] S_HALTING = FT_HALTING;
   localparam logic [2:0] S_RESTORE = FT_RESTORE;
   localparam logic [2:0] S_SET_PC  = FT_SET_PC;
   localparam logic [2:0] S_RELEASE = FT_RELEASE;

   localparam int BEAT_WIDTH = ADDR_WIDTH + DATA_WIDTH;
   localparam int RCNT_WIDTH = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCNT_WIDTH-1:0] RCNT_LOAD = RCNT_WIDTH'(RST_CYCLES - 1);
   localparam logic [RCNT_WIDTH-1:0] RCNT_ZERO = {RCNT_WIDTH{1'b0}};
   localparam logic [RCNT_WIDTH-1:0] RCNT_ONE  = RCNT_WIDTH'(1);

   logic [2:0]            state_r;
   logic                  resume_pend_r;
   logic                  rst_pend_r;
   logic                  core_halt_r;
   logic                  core_rst_r;
   logic                  done_r;
   logic                  overflow_r;
   logic [DATA_WIDTH-1:0] pc_r;
   logic [RCNT_WIDTH-1:0] rst_cnt_r;
   logic [CNT_WIDTH-1:0]  rec_cnt_r;

   logic                  busy_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  release_done_s;
   logic                  rst_pend_nxt_s;
   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic [BEAT_WIDTH-1:0] fifo_head_s;
   logic                  dbg_req_s;
   logic                  dbg_pc_sel_s;
   logic [ADDR_WIDTH-1:0] dbg_addr_s;
   logic [DATA_WIDTH-1:0] dbg_wdata_s;

   assign busy_s = (state_r != S_IDLE);
   // The comparator never waits, so beats are captured in every busy state.
   assign push_s = busy_s & bus.shift_i;
   assign pop_s  = (state_r == S_RESTORE) & ~fifo_empty_s & bus.dbg_gnt_i;
   // RELEASE ends once the reset pulse (if any) has run its full length.
   assign release_done_s = (state_r == S_RELEASE) & ~(core_rst_r & (rst_cnt_r != RCNT_ZERO));
   // A reset_i arriving on the PC-write grant cycle must still produce the pulse.
   assign rst_pend_nxt_s = rst_pend_r | bus.reset_i;

   ft_sync_fifo #(
      .WIDTH (BEAT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_beat_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (release_done_s),
      .push  (push_s),
      .pop   (pop_s),
      .wdata ({bus.addr_i, bus.data_i}),
      .rdata (fifo_head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Main recovery FSM with core halt/reset drives, done pulse and recovery counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r     <= S_IDLE;
         core_halt_r <= 1'b0;
         core_rst_r  <= 1'b0;
         rst_cnt_r   <= RCNT_ZERO;
         done_r      <= 1'b0;
         rec_cnt_r   <= {CNT_WIDTH{1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (bus.halt_i) begin
                  state_r     <= S_HALTING;
                  core_halt_r <= 1'b1;
               end
            end
            S_HALTING: begin
               if (bus.halted_i) state_r <= S_RESTORE;
            end
            S_RESTORE: begin
               if (resume_pend_r & fifo_empty_s & ~push_s) state_r <= S_SET_PC;
            end
            S_SET_PC: begin
               if (bus.dbg_gnt_i) begin
                  state_r    <= S_RELEASE;
                  core_rst_r <= rst_pend_nxt_s;
                  rst_cnt_r  <= RCNT_LOAD;
               end
            end
            S_RELEASE: begin
               if (release_done_s) begin
                  state_r     <= S_IDLE;
                  core_halt_r <= 1'b0;
                  core_rst_r  <= 1'b0;
                  done_r      <= 1'b1;
                  rec_cnt_r   <= cnt_sat_inc(rec_cnt_r);
               end else begin
                  rst_cnt_r <= rst_cnt_r - RCNT_ONE;
               end
            end
            default: begin
               state_r     <= S_IDLE;
               core_halt_r <= 1'b0;
               core_rst_r  <= 1'b0;
            end
         endcase
      end
   end

   // Pending resume/reset flags and safe-PC latch; only live while busy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         resume_pend_r <= 1'b0;
         rst_pend_r    <= 1'b0;
         pc_r          <= {DATA_WIDTH{1'b0}};
      end else if (release_done_s) begin
         resume_pend_r <= 1'b0;
         rst_pend_r    <= 1'b0;
      end else if (busy_s) begin
         if (bus.resume_i) begin
            resume_pend_r <= 1'b1;
            pc_r          <= bus.spc_i;
         end
         if (bus.reset_i) rst_pend_r <= 1'b1;
      end
   end

   // Sticky beat-drop flag; a simultaneous pop frees the slot so that is not a drop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_r <= 1'b0;
      end else if (push_s & fifo_full_s & ~pop_s) begin
         overflow_r <= 1'b1;
      end
   end

   // Debug write request decode; address/data are forced to zero when idle.
   always_comb begin
      dbg_req_s    = 1'b0;
      dbg_pc_sel_s = 1'b0;
      dbg_addr_s   = {ADDR_WIDTH{1'b0}};
      dbg_wdata_s  = {DATA_WIDTH{1'b0}};
      case (state_r)
         S_RESTORE: begin
            if (!fifo_empty_s) begin
               dbg_req_s   = 1'b1;
               dbg_addr_s  = fifo_head_s[BEAT_WIDTH-1:DATA_WIDTH];
               dbg_wdata_s = fifo_head_s[DATA_WIDTH-1:0];
            end else begin
               dbg_req_s   = 1'b0;
            end
         end
         S_SET_PC: begin
            dbg_req_s    = 1'b1;
            dbg_pc_sel_s = 1'b1;
            dbg_wdata_s  = pc_r;
         end
         default: begin
            dbg_req_s    = 1'b0;
         end
      endcase
   end

   assign bus.core_halt_o    = core_halt_r;
   assign bus.core_rst_o     = core_rst_r;
   assign bus.dbg_req_o      = dbg_req_s;
   assign bus.dbg_pc_sel_o   = dbg_pc_sel_s;
   assign bus.dbg_addr_o     = dbg_addr_s;
   assign bus.dbg_wdata_o    = dbg_wdata_s;
   assign bus.busy_o         = busy_s;
   assign bus.done_o         = done_r;
   assign bus.overflow_o     = overflow_r;
   assign bus.recovery_cnt_o = rec_cnt_r;
endmodule
